// File: rtl/onn_ser_pkg.sv
// ============================================================================
// Module : onn_ser_pkg
// Brief  : Shared types and constants for the ONN phase serializer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package onn_ser_pkg;

    localparam int PHASE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_DONE  = 2'd3
    } ser_state_e;

    // Counter must address TOTAL-1 and never be narrower than one bit.
    function automatic int cnt_width(input int total);
        return (total < 2) ? 1 : $clog2(total);
    endfunction

endpackage

`default_nettype wire

// File: rtl/onn_phase_serializer_if.sv
// ============================================================================
// Module : onn_phase_serializer_if
// Brief  : Phase-capture / serial-out bus between ONN core, serializer, host.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface onn_phase_serializer_if
    import onn_ser_pkg::*;
#(
    parameter int N  = 210,
    parameter int PW = PHASE_W
) ();

    logic [0:PW*N-1] phi_in;
    logic            start;
    logic            tx_ready;
    logic            sdo;
    logic            sdo_valid;
    logic            sof;
    logic            eof;
    logic            busy;
    logic            done;

    modport master (
        input  phi_in, start, tx_ready,
        output sdo, sdo_valid, sof, eof, busy, done
    );

    modport slave (
        output phi_in, start, tx_ready,
        input  sdo, sdo_valid, sof, eof, busy, done
    );

endinterface

`default_nettype wire

// File: rtl/onn_ser_bitcnt.sv
// ============================================================================
// Module : onn_ser_bitcnt
// Brief  : Loadable up-counter with enable; saturates at TERM and flags it.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module onn_ser_bitcnt #(
    parameter int WIDTH = 1,
    parameter int TERM  = 0
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load_i,
    input  wire logic [WIDTH-1:0] load_val_i,
    input  wire logic             en_i,
    output logic      [WIDTH-1:0] cnt_o,
    output logic                  tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign tc_o  = (cnt_q == WIDTH'(TERM));
    assign cnt_o = cnt_q;

    // Holding at TERM keeps a power-of-two frame from wrapping to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/onn_phase_serializer.sv
// ============================================================================
// Module : onn_phase_serializer
// Brief  : Captures the ONN phase vector and shifts it out serially.
//          Optional trailing even-parity bit when ONN_SER_PARITY_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module onn_phase_serializer
    import onn_ser_pkg::*;
#(
    parameter int N  = 210,
    parameter int PW = PHASE_W
) (
    input  wire logic               sclk,
    input  wire logic               re,
    onn_phase_serializer_if.master  bus
);

    localparam int TOTAL = PW * N;
    localparam int CW    = cnt_width(TOTAL);

    ser_state_e       state_q;
    ser_state_e       state_d;
    logic [0:TOTAL-1] shreg_q;
    logic [0:TOTAL-1] shreg_d;
    logic [CW-1:0]    cnt;
    logic             cnt_tc;
    logic             cnt_load;
    logic             cnt_en;

`ifdef ONN_SER_PARITY_EN
    logic             parity_q;
    logic             parity_d;
`endif

    onn_ser_bitcnt #(
        .WIDTH (CW),
        .TERM  (TOTAL - 1)
    ) u_bitcnt (
        .clk        (sclk),
        .rst_n      (re),
        .load_i     (cnt_load),
        .load_val_i ('0),
        .en_i       (cnt_en),
        .cnt_o      (cnt),
        .tc_o       (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
`ifdef ONN_SER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_SHIFT;
                    shreg_d  = bus.phi_in;
                    cnt_load = 1'b1;
`ifdef ONN_SER_PARITY_EN
                    parity_d = ^bus.phi_in;
`endif
                end
            end
            ST_SHIFT: begin
                if (bus.tx_ready) begin
                    shreg_d = {shreg_q[1:TOTAL-1], 1'b0};
                    cnt_en  = 1'b1;
                    if (cnt_tc) begin
`ifdef ONN_SER_PARITY_EN
                        state_d = ST_PAR;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef ONN_SER_PARITY_EN
            ST_PAR: begin
                if (bus.tx_ready) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (!re) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
`ifdef ONN_SER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
`ifdef ONN_SER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Outputs decode registered state only; tx_ready/start never reach them.
    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = (state_q == ST_DONE);
    assign bus.sof  = (state_q == ST_SHIFT) && (cnt == '0);

`ifdef ONN_SER_PARITY_EN
    assign bus.sdo_valid = (state_q == ST_SHIFT) || (state_q == ST_PAR);
    assign bus.sdo       = (state_q == ST_SHIFT) ? shreg_q[0] :
                           (state_q == ST_PAR)   ? parity_q   : 1'b0;
    assign bus.eof       = (state_q == ST_PAR);
`else
    assign bus.sdo_valid = (state_q == ST_SHIFT);
    assign bus.sdo       = (state_q == ST_SHIFT) ? shreg_q[0] : 1'b0;
    assign bus.eof       = (state_q == ST_SHIFT) && cnt_tc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_onn_phase_serializer.sv
// ============================================================================
// Module : tb_onn_phase_serializer
// Brief  : Directed self-checking bench for N=2 and N=1 serializers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_onn_phase_serializer;

`ifdef ONN_SER_PARITY_EN
    localparam int FL2 = 9;
    localparam int FL1 = 5;
`else
    localparam int FL2 = 8;
    localparam int FL1 = 4;
`endif

    logic sclk = 1'b0;
    logic re   = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 sclk = ~sclk;

    onn_phase_serializer_if #(.N(2)) b2 ();
    onn_phase_serializer_if #(.N(1)) b1 ();

    onn_phase_serializer #(.N(2)) dut2 (.sclk(sclk), .re(re), .bus(b2));
    onn_phase_serializer #(.N(1)) dut1 (.sclk(sclk), .re(re), .bus(b1));

    task automatic cyc();
        @(posedge sclk);
        #1;
    endtask

    // {sdo_valid, sdo, sof, eof, busy, done}
    function automatic logic [5:0] o2();
        return {b2.sdo_valid, b2.sdo, b2.sof, b2.eof, b2.busy, b2.done};
    endfunction

    function automatic logic [5:0] o1();
        return {b1.sdo_valid, b1.sdo, b1.sof, b1.eof, b1.busy, b1.done};
    endfunction

    // Expected frame bit k: data bits in index order, then even parity.
    function automatic logic fbit2(input logic [0:7] v, input int k);
        if (k < 8) return v[k];
        return ^v;
    endfunction

    function automatic logic fbit1(input logic [0:3] v, input int k);
        if (k < 4) return v[k];
        if (k == 4) return ^v;
        return 1'b0;
    endfunction

    function automatic logic [5:0] exp2(input logic [0:7] v, input int k);
        return {1'b1, fbit2(v, k), k == 0, k == FL2 - 1, 1'b1, 1'b0};
    endfunction

    task automatic test_reset();
        re = 1'b0;
        cyc();
        cyc();
        checks++;
        if (o2() !== 6'b0) begin
            errors++; $display("FAIL reset_n2: got %b expected %b", o2(), 6'b0);
        end
        checks++;
        if (o1() !== 6'b0) begin
            errors++; $display("FAIL reset_n1: got %b expected %b", o1(), 6'b0);
        end
        re = 1'b1;
        cyc();
        checks++;
        if (o2() !== 6'b0) begin
            errors++; $display("FAIL idle_after_reset: got %b expected %b", o2(), 6'b0);
        end
    endtask

    task automatic test_basic();
        logic [0:7] v;
        v = 8'b1011_0010;
        b2.phi_in = v; b2.tx_ready = 1'b1; b2.start = 1'b1;
        cyc();
        b2.start = 1'b0;
        for (int k = 0; k < FL2; k++) begin
            checks++;
            if (o2() !== exp2(v, k)) begin
                errors++; $display("FAIL basic_bit%0d: got %b expected %b", k, o2(), exp2(v, k));
            end
            cyc();
        end
        checks++;
        if (o2() !== 6'b000011) begin
            errors++; $display("FAIL basic_done: got %b expected %b", o2(), 6'b000011);
        end
        cyc();
        checks++;
        if (o2() !== 6'b0) begin
            errors++; $display("FAIL basic_idle: got %b expected %b", o2(), 6'b0);
        end
    endtask

    task automatic test_stall();
        logic [0:7] v;
        v = 8'b1011_0010;
        b2.phi_in = v; b2.tx_ready = 1'b1; b2.start = 1'b1;
        cyc();
        b2.start = 1'b0;
        for (int k = 0; k < FL2; k++) begin
            if (k == 3) begin
                b2.tx_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    checks++;
                    if (o2() !== exp2(v, 3)) begin
                        errors++; $display("FAIL stall_hold%0d: got %b expected %b", s, o2(), exp2(v, 3));
                    end
                    cyc();
                end
                b2.tx_ready = 1'b1;
            end
            checks++;
            if (o2() !== exp2(v, k)) begin
                errors++; $display("FAIL stall_bit%0d: got %b expected %b", k, o2(), exp2(v, k));
            end
            cyc();
        end
        checks++;
        if (o2() !== 6'b000011) begin
            errors++; $display("FAIL stall_done: got %b expected %b", o2(), 6'b000011);
        end
        cyc();
    endtask

    task automatic test_start_ignored();
        logic [0:7] v;
        logic [0:7] nv;
        v  = 8'b1011_0010;
        nv = 8'b0101_1010;
        b2.phi_in = v; b2.tx_ready = 1'b1; b2.start = 1'b1;
        cyc();
        b2.start = 1'b0;
        for (int k = 0; k < FL2; k++) begin
            if (k == 2) begin
                b2.start = 1'b1; b2.phi_in = nv;
            end else begin
                b2.start = 1'b0;
            end
            checks++;
            if (o2() !== exp2(v, k)) begin
                errors++; $display("FAIL ignore_bit%0d: got %b expected %b", k, o2(), exp2(v, k));
            end
            cyc();
        end
        // start held through DONE is dropped there and taken in the idle cycle
        b2.start = 1'b1;
        checks++;
        if (o2() !== 6'b000011) begin
            errors++; $display("FAIL ignore_done: got %b expected %b", o2(), 6'b000011);
        end
        cyc();
        checks++;
        if (o2() !== 6'b0) begin
            errors++; $display("FAIL start_in_done_dropped: got %b expected %b", o2(), 6'b0);
        end
        cyc();
        b2.start = 1'b0;
        for (int k = 0; k < FL2; k++) begin
            checks++;
            if (o2() !== exp2(nv, k)) begin
                errors++; $display("FAIL next_frame_bit%0d: got %b expected %b", k, o2(), exp2(nv, k));
            end
            cyc();
        end
        checks++;
        if (o2() !== 6'b000011) begin
            errors++; $display("FAIL next_frame_done: got %b expected %b", o2(), 6'b000011);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        logic [0:7] v;
        logic [0:7] v2;
        v  = 8'b1011_0010;
        v2 = 8'b1100_0101;
        b2.phi_in = v; b2.tx_ready = 1'b1; b2.start = 1'b1;
        cyc();
        b2.start = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            checks++;
            if (o2() !== exp2(v, k)) begin
                errors++; $display("FAIL pre_abort_bit%0d: got %b expected %b", k, o2(), exp2(v, k));
            end
            if (k < 4) cyc();
        end
        re = 1'b0;
        cyc();
        checks++;
        if (o2() !== 6'b0) begin
            errors++; $display("FAIL abort_outputs: got %b expected %b", o2(), 6'b0);
        end
        re = 1'b1;
        cyc();
        checks++;
        if (o2() !== 6'b0) begin
            errors++; $display("FAIL abort_no_done: got %b expected %b", o2(), 6'b0);
        end
        b2.phi_in = v2; b2.start = 1'b1;
        cyc();
        b2.start = 1'b0;
        for (int k = 0; k < FL2; k++) begin
            checks++;
            if (o2() !== exp2(v2, k)) begin
                errors++; $display("FAIL clean_bit%0d: got %b expected %b", k, o2(), exp2(v2, k));
            end
            cyc();
        end
        checks++;
        if (o2() !== 6'b000011) begin
            errors++; $display("FAIL clean_done: got %b expected %b", o2(), 6'b000011);
        end
        cyc();
    endtask

    task automatic test_single_one();
        logic [0:7] v;
        v = 8'b1000_0000;
        b2.phi_in = v; b2.tx_ready = 1'b1; b2.start = 1'b1;
        cyc();
        b2.start = 1'b0;
        for (int k = 0; k < FL2; k++) begin
            checks++;
            if (o2() !== exp2(v, k)) begin
                errors++; $display("FAIL one_bit%0d: got %b expected %b", k, o2(), exp2(v, k));
            end
            cyc();
        end
        checks++;
        if (o2() !== 6'b000011) begin
            errors++; $display("FAIL one_done: got %b expected %b", o2(), 6'b000011);
        end
        cyc();
    endtask

    task automatic test_n1_toggle();
        logic [0:3] v;
        int         k;
        int         dones;
        v = 4'b0001;
        k = 0;
        dones = 0;
        b1.phi_in = v; b1.tx_ready = 1'b0; b1.start = 1'b1;
        cyc();
        b1.start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            b1.tx_ready = (c % 2) == 1;
            if (b1.done) dones++;
            if (b1.sdo_valid && b1.tx_ready) begin
                checks++;
                if ({b1.sdo, b1.sof, b1.eof} !== {fbit1(v, k), k == 0, k == FL1 - 1}) begin
                    errors++;
                    $display("FAIL n1_bit%0d: got %b expected %b", k, {b1.sdo, b1.sof, b1.eof},
                             {fbit1(v, k), k == 0, k == FL1 - 1});
                end
                k++;
            end
            cyc();
        end
        checks++;
        if (k !== FL1) begin
            errors++; $display("FAIL n1_bit_count: got %0d expected %0d", k, FL1);
        end
        checks++;
        if (dones !== 1) begin
            errors++; $display("FAIL n1_done_count: got %0d expected %0d", dones, 1);
        end
        checks++;
        if (o1() !== 6'b0) begin
            errors++; $display("FAIL n1_idle: got %b expected %b", o1(), 6'b0);
        end
        b1.tx_ready = 1'b0;
    endtask

    initial begin
        b2.phi_in = '0; b2.start = 1'b0; b2.tx_ready = 1'b0;
        b1.phi_in = '0; b1.start = 1'b0; b1.tx_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_single_one();
        test_n1_toggle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/onn_phase_serializer.md
Name: onn_phase_serializer

Overview:
- Transmit side of the ONN serial interface: the ONN is loaded serially, and this block reads the settled phase vector back out over a single serial line.
- On a start strobe it captures the parallel phase bus (4 bits per neuron, N neurons) and shifts it out one bit per accepted cycle.
- Provides frame markers and downstream back-pressure.
- Sits between the ONN core's phase output and the off-chip/host readout path.

Parameters:
- N, 210, number of neurons; frame length TOTAL = 4*N data bits.
- PW, 4, phase bits per neuron (fixed at 4; exposed for the package constant only).

Ports:
- sclk, input, 1, system clock; all logic on rising edge.
- re, input, 1, reset: synchronous, active-low.
- phi_in, input, [0:4*N-1], phase vector from ONN core; sampled only on the accepted start cycle.
- start, input, 1, request to capture phi_in and send a frame.
- tx_ready, input, 1, downstream accepts the current bit this cycle.
- sdo, output, 1, serial data bit.
- sdo_valid, output, 1, sdo holds a frame bit.
- sof, output, 1, high with the first frame bit.
- eof, output, 1, high with the last frame bit.
- busy, output, 1, frame in progress; start ignored.
- done, output, 1, one-cycle pulse after the last bit is accepted.

Behaviour:
- Reset (re==0 at sclk edge) forces: state IDLE, shift register 0, bit counter 0.
  - All outputs go to 0: sdo, sdo_valid, sof, eof, busy, done.
  - A reset mid-frame aborts the frame; no done pulse is produced.
- States: IDLE, SHIFT, (PAR), DONE.
- IDLE:
  - busy=0, sdo_valid=0.
  - start==1: load shreg<=phi_in, cnt<=0, go SHIFT. busy=1 from the next cycle.
- SHIFT:
  - sdo_valid=1; sdo=shreg[0], so phi_in[0] is sent first and phi_in[4N-1] last.
  - sof=1 when cnt==0; eof=1 when cnt==TOTAL-1 (parity build: eof moves to PAR).
  - Accept = sdo_valid && tx_ready. On accept: shreg shifts one position toward index 0, cnt increments.
  - tx_ready==0: sdo, sof, eof and cnt hold unchanged, with no limit on stall length.
  - Accept at cnt==TOTAL-1: go DONE (or PAR).
- DONE:
  - One cycle: done=1, busy=1, sdo_valid=0. Then IDLE.
- start is accepted only in IDLE; start in SHIFT/PAR/DONE is dropped, not queued.
  - The earliest next frame is start in the cycle after DONE, i.e. one idle cycle between frames.
- Output timing: sdo, sdo_valid, sof, eof, busy and done depend only on registered state. There is no combinational path from tx_ready or start to any output.
- Counter: $clog2(4*N) bits (min 1). It never wraps; it is cleared on capture.
- N=1: 4-bit frame; sof and eof on separate bits. Frame length is identical for all-zero and all-one phi_in.
- Throughput: TOTAL bits in TOTAL cycles with tx_ready held high. Total frame time is TOTAL+2 cycles from start to return to IDLE.

Optional Feature:
- Macro ONN_SER_PARITY_EN.
- Defined:
  - Even parity (XOR of all 4N captured bits) is computed at capture.
  - After the last data bit, state PAR sends the parity bit with sdo_valid=1, eof=1, under the same tx_ready stall rules. The last data bit has eof=0.
  - Frame length TOTAL+1.
- Undefined: no PAR state or parity register; frame is exactly 4N bits.

Decomposition:
- Package onn_ser_pkg:
  - State enum (IDLE, SHIFT, PAR, DONE) with fixed 2-bit encoding.
  - Constant PHASE_W=4.
  - Function for counter width.
- One natural sub-module, onn_ser_bitcnt: a loadable counter with enable and a terminal-count flag, used for cnt/eof generation.
- Everything else is inline.

Test Plan:
- N=2, phi_in=8'b1011_0010, start pulse, tx_ready=1.
  - sdo sequence 1,0,1,1,0,0,1,0 on 8 consecutive cycles.
  - sof on bit 0, eof on bit 7, done one cycle later, busy low the cycle after.
- Same frame with tx_ready=0 for 3 cycles during bit 3.
  - sdo=1 and sdo_valid=1 hold for 4 cycles; sequence unchanged; eof still only on bit 7.
- Start re-asserted during SHIFT with a different phi_in: ignored, original frame completes.
  - Start in the cycle after DONE sends the new vector.
- re=0 during bit 4: next cycle all outputs 0, state IDLE, no done.
  - A following start sends a full clean frame.
- ONN_SER_PARITY_EN, N=2:
  - phi_in=8'b1011_0010 gives a 9th bit 0 with eof on it.
  - phi_in=8'b1000_0000 gives a 9th bit 1.
- N=1, phi_in=4'b0001 with tx_ready toggling every cycle.
  - Bits 0,0,0,1 delivered on accepted cycles only; done exactly once.
